// File: rtl/fp_pkg.sv
// Shared IEEE 754 single-precision constants, FSM state encoding and operand decode helper
// for the iterative floating-point divider.
package fp_pkg;

  localparam int unsigned SIGN_W = 1;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;

  localparam int BIAS = 127;
  localparam int EMIN = -126;
  localparam int EMAX = 127;

  localparam logic [31:0] QNAN    = 32'hFFC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int unsigned QUO_W     = 27;
  localparam int unsigned UFLOW_MAX = 26;

  // Working exponents need headroom beyond 8 bits for denormal normalization and overflow.
  typedef logic signed [9:0] exp_t;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StNorm,
    StDiv,
    StAlign,
    StUflow,
    StRound,
    StPack
  } state_e;

  typedef struct packed {
    exp_t              exp;
    logic [MANT_W-1:0] mant;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
  } unpacked_t;

  function automatic unpacked_t unpack(input logic [31:0] x);
    unpacked_t u;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e         = x[30:23];
    f         = x[22:0];
    u.is_nan  = (e == 8'hFF) && (f != '0);
    u.is_inf  = (e == 8'hFF) && (f == '0);
    u.is_zero = (e == 8'h00) && (f == '0);
    if (e == 8'h00) begin
      u.exp  = exp_t'(EMIN);
      u.mant = {1'b0, f};
    end else begin
      u.exp  = exp_t'({2'b00, e}) - exp_t'(BIAS);
      u.mant = {1'b1, f};
    end
    return u;
  endfunction

endpackage

// File: rtl/fdiv_mant_core.sv
// Restoring radix-2 mantissa divider: 27 quotient bits, MSB weighting 2^0, one bit per cycle.
// The first bit is produced on the go edge itself, so valid_o rises 26 cycles later.
module fdiv_mant_core
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic [MANT_W-1:0] ma_i,
  input  logic [MANT_W-1:0] mb_i,
  output logic [QUO_W-1:0]  q_o,
  output logic [MANT_W:0]   rem_o,
  output logic              valid_o
);

  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W-1:0] div_q, div_d;
  logic [QUO_W-1:0]  quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;

  logic [MANT_W:0]   rem_src;
  logic [MANT_W-1:0] div_src;
  logic [MANT_W-1:0] diff;
  logic              ge;

  always_comb begin
    rem_src = go_i ? {1'b0, ma_i} : rem_q;
    div_src = go_i ? mb_i : div_q;
    ge      = rem_src >= {1'b0, div_src};
    // Partial remainder is always below 2*divisor, so the difference fits the mantissa width.
    diff    = ge ? MANT_W'(rem_src - {1'b0, div_src}) : rem_src[MANT_W-1:0];

    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (go_i) begin
      rem_d = {diff, 1'b0};
      div_d = mb_i;
      quo_d = {{(QUO_W-1){1'b0}}, ge};
      cnt_d = 5'(QUO_W - 1);
    end else if (cnt_q != '0) begin
      rem_d   = {diff, 1'b0};
      quo_d   = {quo_q[QUO_W-2:0], ge};
      cnt_d   = cnt_q - 5'd1;
      valid_d = (cnt_q == 5'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = quo_q;
  assign rem_o   = rem_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fdivider.sv
// Multi-cycle IEEE 754 single-precision divider with round-to-nearest-even and
// denormal support; the mantissa quotient comes from fdiv_mant_core.
module fdivider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic        busy,
  output logic        done
);

  state_e state_q, state_d;

  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic              special_q, special_d;
  logic [31:0]       spec_res_q, spec_res_d;
  exp_t              ea_q, ea_d, eb_q, eb_d, ez_q, ez_d;
  logic [MANT_W-1:0] ma_q, ma_d, mb_q, mb_d, mant_q, mant_d;
  logic              grd_q, grd_d, rnd_q, rnd_d, stk_q, stk_d;
  logic [4:0]        ucnt_q, ucnt_d;
  logic [31:0]       z_q, z_d;
  logic              done_q, done_d;

  unpacked_t         ua, ub;
  logic              sp_nan, sp_inf, sp_zero, is_special, res_sign;
  logic [31:0]       spec_res;
  logic              go, core_valid, inc;
  logic [QUO_W-1:0]  quo;
  logic [MANT_W:0]   rem;
  logic [MANT_W:0]   rsum;
  logic [EXP_W-1:0]  exp_field;

  fdiv_mant_core u_core (
    .clk     (clk),
    .rst     (rst),
    .go_i    (go),
    .ma_i    (ma_d),
    .mb_i    (mb_d),
    .q_o     (quo),
    .rem_o   (rem),
    .valid_o (core_valid)
  );

  // Operand classification and special-result selection.
  always_comb begin
    ua         = unpack(a_q);
    ub         = unpack(b_q);
    res_sign   = a_q[31] ^ b_q[31];
    sp_nan     = ua.is_nan | ub.is_nan | (ua.is_zero & ub.is_zero) | (ua.is_inf & ub.is_inf);
    sp_inf     = ua.is_inf | ub.is_zero;
    sp_zero    = ub.is_inf | ua.is_zero;
    is_special = sp_nan | sp_inf | sp_zero;
    if (sp_nan) begin
      spec_res = QNAN;
    end else if (sp_inf) begin
      spec_res = POS_INF | {res_sign, 31'b0};
    end else begin
      spec_res = {res_sign, 31'b0};
    end
  end

  // Datapath next-state.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ez_d       = ez_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    mant_d     = mant_q;
    grd_d      = grd_q;
    rnd_d      = rnd_q;
    stk_d      = stk_q;
    ucnt_d     = ucnt_q;
    z_d        = z_q;
    done_d     = 1'b0;
    rsum       = {1'b0, mant_q} + 25'd1;
    inc        = grd_q & (rnd_q | stk_q | mant_q[0]);
    exp_field  = ez_q[7:0] + 8'd127;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d = a;
          b_d = b;
        end
      end
      StUnpack: begin
        sign_d     = res_sign;
        special_d  = is_special;
        spec_res_d = spec_res;
        ea_d       = ua.exp;
        eb_d       = ub.exp;
        ma_d       = ua.mant;
        mb_d       = ub.mant;
      end
      StNorm: begin
        if (!ma_q[MANT_W-1]) begin
          ma_d = ma_q << 1;
          ea_d = ea_q - 10'sd1;
        end
        if (!mb_q[MANT_W-1]) begin
          mb_d = mb_q << 1;
          eb_d = eb_q - 10'sd1;
        end
      end
      StDiv: begin
        ez_d = ea_q - eb_q;
      end
      StAlign: begin
        ucnt_d = '0;
        if (quo[26]) begin
          mant_d = quo[26:3];
          grd_d  = quo[2];
          rnd_d  = quo[1];
          stk_d  = quo[0] | (rem != '0);
        end else begin
          mant_d = quo[25:2];
          grd_d  = quo[1];
          rnd_d  = quo[0];
          stk_d  = (rem != '0);
          ez_d   = ez_q - 10'sd1;
        end
      end
      StUflow: begin
        mant_d = mant_q >> 1;
        grd_d  = mant_q[0];
        rnd_d  = grd_q;
        stk_d  = stk_q | rnd_q;
        ez_d   = ez_q + 10'sd1;
        ucnt_d = ucnt_q + 5'd1;
        // Beyond the cap every significant bit has left; only sticky survives.
        if ((ucnt_q == 5'(UFLOW_MAX - 1)) && (ez_d < exp_t'(EMIN))) begin
          mant_d = '0;
          grd_d  = 1'b0;
          rnd_d  = 1'b0;
          ez_d   = exp_t'(EMIN);
        end
      end
      StRound: begin
        if (inc) begin
          if (rsum[MANT_W]) begin
            mant_d = 24'h80_0000;
            ez_d   = ez_q + 10'sd1;
          end else begin
            mant_d = rsum[MANT_W-1:0];
          end
        end
      end
      StPack: begin
        done_d = 1'b1;
        if (special_q) begin
          z_d = spec_res_q;
        end else if (ez_q > exp_t'(EMAX)) begin
          z_d = {sign_q, 8'hFF, 23'h0};
        end else if ((ez_q == exp_t'(EMIN)) && !mant_q[MANT_W-1]) begin
          z_d = {sign_q, 8'h00, mant_q[22:0]};
        end else begin
          z_d = {sign_q, exp_field, mant_q[22:0]};
        end
      end
      default: ;
    endcase
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StUnpack;
      StUnpack: begin
        if (is_special) begin
          state_d = StPack;
        end else if (ua.mant[MANT_W-1] && ub.mant[MANT_W-1]) begin
          state_d = StDiv;
        end else begin
          state_d = StNorm;
        end
      end
      // Leave on the same edge as the final shift so NORM costs exactly one cycle per shift.
      StNorm:   if (ma_d[MANT_W-1] && mb_d[MANT_W-1]) state_d = StDiv;
      StDiv:    if (core_valid) state_d = StAlign;
      StAlign:  state_d = (ez_d < exp_t'(EMIN)) ? StUflow : StRound;
      StUflow:  if (ez_d >= exp_t'(EMIN)) state_d = StRound;
      StRound:  state_d = StPack;
      StPack:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != StIdle);
    go   = (state_d == StDiv) && (state_q != StDiv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      ez_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      mant_q     <= '0;
      grd_q      <= 1'b0;
      rnd_q      <= 1'b0;
      stk_q      <= 1'b0;
      ucnt_q     <= '0;
      z_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ez_q       <= ez_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      mant_q     <= mant_d;
      grd_q      <= grd_d;
      rnd_q      <= rnd_d;
      stk_q      <= stk_d;
      ucnt_q     <= ucnt_d;
      z_q        <= z_d;
      done_q     <= done_d;
    end
  end

  assign z    = z_q;
  assign done = done_q;

endmodule

// File: tb/tb_fdivider.sv
// Scoreboard bench for fdivider: directed corner cases plus randomized operands checked
// against an exact-integer IEEE division model.
module tb_fdivider;

  logic        clk, rst, start;
  logic [31:0] a, b, z;
  logic        busy, done;

  fdivider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [31:0] z;
    int          lat;
    int          t0;
  } exp_s;

  exp_s exp_q[$];
  int   total, bad, cycle, n_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  // Exact reference: normalize, divide with wide integers, round to nearest even.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          output int lat);
    logic        s, xn, yn, xi, yi, xz, yz, stk, up;
    logic [63:0] mx, my, num, qv, rest, half, m;
    int          ex, ey, nx, ny, e, big_e, lsb, sh, uf;
    s   = x[31] ^ y[31];
    xn  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz  = (x[30:0] == 0);
    yz  = (y[30:0] == 0);
    lat = 2;
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'hFFC0_0000;
    if (xi || yz) return {s, 8'hFF, 23'h0};
    if (yi || xz) return {s, 31'h0};
    mx = {40'b0, (x[30:23] != 0), x[22:0]};
    my = {40'b0, (y[30:23] != 0), y[22:0]};
    ex = (x[30:23] == 0) ? -149 : int'(x[30:23]) - 150;
    ey = (y[30:23] == 0) ? -149 : int'(y[30:23]) - 150;
    nx = 0;
    ny = 0;
    while (!mx[23]) begin mx = mx << 1; ex--; nx++; end
    while (!my[23]) begin my = my << 1; ey--; ny++; end
    e     = ex - ey;
    num   = mx << 39;
    qv    = num / my;
    stk   = (num % my) != 0;
    big_e = (qv[39] ? 39 : 38) + e - 39;
    uf    = (big_e < -126) ? (-126 - big_e) : 0;
    if (uf > 26) uf = 26;
    lat   = 31 + ((nx > ny) ? nx : ny) + uf;
    lsb   = (big_e < -126) ? -149 : big_e - 23;
    sh    = lsb - (e - 39);
    if (sh > 40) begin
      m  = 0;
      up = 1'b0;
    end else begin
      m    = qv >> sh;
      rest = qv & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (rest > half) || ((rest == half) && (stk || m[0]));
    end
    m = m + 64'(up);
    if (m[24]) begin
      m = m >> 1;
      lsb++;
    end
    if (!m[23]) return {s, 8'h00, m[22:0]};
    if (lsb + 150 > 254) return {s, 8'hFF, 23'h0};
    return {s, 8'(lsb + 150), m[22:0]};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  initial begin
    exp_s e;
    logic prev_done;
    prev_done = 1'b0;
    n_done    = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("done_gap", {31'b0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got z=%08h want no done (cycle %0d)", z, cycle);
        end else begin
          e = exp_q.pop_front();
          chk("z", z, e.z);
          chk("latency", 32'(cycle - e.t0), 32'(e.lat));
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL timeout: got no done in %0d cycles want done", limit);
    exp_q.delete();
  endtask

  // Drives start at the current time; called from a negedge so start lands in the done cycle.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] zz, input int lat);
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back('{z: zz, lat: lat, t0: cycle});
    wait_done(200);
  endtask

  task automatic run_rand(input logic [31:0] aa, input logic [31:0] bb);
    logic [31:0] zz;
    int          lat;
    zz = ref_div(aa, bb, lat);
    run_op(aa, bb, zz, lat);
  endtask

  function automatic logic [31:0] rand_fp();
    int          c;
    logic [31:0] r;
    c = $urandom_range(0, 15);
    r = $urandom;
    case (c)
      0, 1: r[30:23] = 8'h00;
      2: begin
        r[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) r[22:0] = '0;
      end
      3: r[30:0] = '0;
      4, 5: r[30:23] = 8'($urandom_range(230, 254));
      6, 7: r[30:23] = 8'($urandom_range(1, 30));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  initial begin
    int nd;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'h4040_0000;
    b     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    chk("reset_z", z, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 31);
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 31);
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 2);
    run_op(32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 2);
    run_op(32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 2);
    run_op(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 31);
    run_op(32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 32);
    // 23 normalization shifts, then 23 underflow shifts back to the denormal range.
    run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 31 + 23 + 23);

    // A start raised while busy must not disturb the operation in flight.
    a     = 32'h3F80_0000;
    b     = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back('{z: 32'h3EAA_AAAB, lat: 31, t0: cycle});
    repeat (4) @(posedge clk);
    #1;
    a     = 32'h4100_0000;
    b     = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // Abort: start, ignored start at t5, reset at t10; no done may follow.
    a     = 32'h40C0_0000;
    b     = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a     = 32'h3F80_0000;
    b     = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_z", z, 32'h0);
    nd = n_done;
    repeat (60) @(negedge clk);
    chk("abort_no_done", 32'(n_done - nd), 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 31);

    for (int i = 0; i < 300; i++) begin
      run_rand(rand_fp(), rand_fp());
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog: got no finish want finish (cycle %0d)", cycle);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
